muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage.
- Sits directly downstream of the ID/EX pipeline register and consumes its E-stage operands and funct3.
- Produces a 32-bit result that the EX-stage result mux selects when an M-extension instruction is in EX.
- Drives a stall request to the hazard unit, which freezes the fetch, decode and ID/EX registers while an operation is in flight.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies take one cycle in MUL; divides use 32-step restoring division on magnitudes.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int DIV_CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_W    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE_W    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [DIV_CNT_W-1:0] CNT_ONE = {{(DIV_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    state_t                 state_r;
    logic [2:0]             op_r;
    logic [XLEN-1:0]        opa_r;
    logic [XLEN-1:0]        opb_r;
    logic [XLEN-1:0]        dvs_r;
    logic [XLEN-1:0]        quo_r;
    logic [XLEN:0]          rem_r;
    logic [DIV_CNT_W-1:0]   cnt_r;
    logic [XLEN-1:0]        result_r;
    logic                   valid_r;

    logic                   in_signed_s;
    logic                   div_zero_s;
    logic                   ovf_s;
    logic [XLEN-1:0]        a_mag_s;
    logic [XLEN-1:0]        b_mag_s;
    logic [XLEN-1:0]        spec_res_s;
    logic [2*XLEN-1:0]      a_w_s;
    logic [2*XLEN-1:0]      b_w_s;
    logic [2*XLEN-1:0]      prod_s;
    logic [XLEN-1:0]        mul_res_s;
    logic [XLEN+1:0]        shift_s;
    logic [XLEN+1:0]        trial_s;
    logic [XLEN:0]          rem_nxt_s;
    logic [XLEN-1:0]        quo_nxt_s;
    logic                   div_signed_s;
    logic [XLEN-1:0]        div_res_s;

    // Operand decode, special-case detection, product and one restoring-division step.
    always_comb begin
        in_signed_s  = ~funct3E[0];
        div_zero_s   = (SrcBE == ZERO_W);
        ovf_s        = in_signed_s && (SrcAE == MIN_W) && (SrcBE == ONES_W);
        a_mag_s      = cond_neg(SrcAE, in_signed_s && SrcAE[XLEN-1]);
        b_mag_s      = cond_neg(SrcBE, in_signed_s && SrcBE[XLEN-1]);
        spec_res_s   = ZERO_W;
        if (funct3E[1]) begin
            spec_res_s = div_zero_s ? SrcAE : ZERO_W;
        end else begin
            spec_res_s = div_zero_s ? ONES_W : MIN_W;
        end

        // 33-bit extension of each operand, then sign-extended further so the 64-bit product is exact.
        a_w_s     = {{(XLEN-1){(op_r[1:0] != 2'b11) & opa_r[XLEN-1]}}, (op_r[1:0] != 2'b11) & opa_r[XLEN-1], opa_r};
        b_w_s     = {{(XLEN-1){(op_r[1:0] == 2'b01) & opb_r[XLEN-1]}}, (op_r[1:0] == 2'b01) & opb_r[XLEN-1], opb_r};
        prod_s    = a_w_s * b_w_s;
        mul_res_s = (op_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

        shift_s = {rem_r, quo_r[XLEN-1]};
        trial_s = shift_s - {2'b00, dvs_r};
        if (trial_s[XLEN+1]) begin
            rem_nxt_s = shift_s[XLEN:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt_s = trial_s[XLEN:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b1};
        end

        div_signed_s = ~op_r[0];
        if (op_r[1]) begin
            div_res_s = cond_neg(rem_nxt_s[XLEN-1:0], div_signed_s && opa_r[XLEN-1]);
        end else begin
            div_res_s = cond_neg(quo_nxt_s, div_signed_s && (opa_r[XLEN-1] ^ opb_r[XLEN-1]));
        end
    end

    // Control FSM with operand latching, iteration state and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            op_r     <= 3'b000;
            opa_r    <= ZERO_W;
            opb_r    <= ZERO_W;
            dvs_r    <= ZERO_W;
            quo_r    <= ZERO_W;
            rem_r    <= {(XLEN+1){1'b0}};
            cnt_r    <= {DIV_CNT_W{1'b0}};
            result_r <= ZERO_W;
            valid_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    valid_r <= 1'b0;
                    if (start) begin
                        op_r  <= funct3E;
                        opa_r <= SrcAE;
                        opb_r <= SrcBE;
                        dvs_r <= b_mag_s;
                        quo_r <= a_mag_s;
                        rem_r <= {(XLEN+1){1'b0}};
                        cnt_r <= {DIV_CNT_W{1'b1}};
                        if (!funct3E[2]) begin
                            state_r <= S_MUL;
                        end else if (div_zero_s || ovf_s) begin
                            result_r <= spec_res_s;
                            valid_r  <= 1'b1;
                            state_r  <= S_DONE;
                        end else begin
                            state_r <= S_DIV;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MUL: begin
                    result_r <= mul_res_s;
                    valid_r  <= 1'b1;
                    state_r  <= S_DONE;
                end
                S_DIV: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    if (cnt_r == {DIV_CNT_W{1'b0}}) begin
                        result_r <= div_res_s;
                        valid_r  <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_DONE: begin
                    valid_r <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the start cycle itself, so busy is decoded from state and start.
    assign busy         = rst_n && (((state_r == S_IDLE) && start) || (state_r == S_MUL) || (state_r == S_DIV));
    assign result_valid = valid_r;
    assign result       = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3E(funct3E),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        r  = 32'd0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Issue one op from the IDLE cycle; returns at #1 after the edge ending DONE with start dropped.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [31:0] res, output int lat,
                         output int bc, output logic done_busy, output logic after_valid);
        bit seen;
        seen = 1'b0;
        lat = 0;
        bc = 0;
        start = 1'b1; funct3E = op; SrcAE = a; SrcBE = b;
        #1;
        if (busy) bc++;
        while (!seen && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (scramble && lat == 1) begin SrcAE = $urandom; SrcBE = $urandom; end
            if (result_valid) seen = 1'b1;
            else if (busy) bc++;
        end
        if (!seen) $display("FAIL timeout op=%0d: no result_valid after %0d cycles", op, lat);
        res = result;
        done_busy = busy;
        @(posedge clk); #1;
        after_valid = result_valid;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; funct3E = 3'd0; SrcAE = 32'd5; SrcBE = 32'd5;
        #2;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", result_valid); else passed++;
        total++; if (result !== 32'd0) $display("FAIL reset_result: got %h want 00000000", result); else passed++;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Directed table runner shared by the multiply, divide and special-case scenarios.
    task automatic run_table(input string tag, input logic [2:0] ops[4], input logic [31:0] as[4],
                             input logic [31:0] bs[4], input logic [31:0] exps[4], input int exp_lat);
        logic [31:0] res;
        int lat, bc;
        logic db, av;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, res, lat, bc, db, av);
            total++; if (res !== exps[i]) $display("FAIL %s_result[%0d]: got %h want %h", tag, i, res, exps[i]); else passed++;
            total++; if (lat != exp_lat) $display("FAIL %s_latency[%0d]: got %0d want %0d", tag, i, lat, exp_lat); else passed++;
            total++; if (bc != exp_lat) $display("FAIL %s_busy_cycles[%0d]: got %0d want %0d", tag, i, bc, exp_lat); else passed++;
            total++; if (db !== 1'b0 || av !== 1'b0) $display("FAIL %s_done_phase[%0d]: busy=%b next_valid=%b want 0 0", tag, i, db, av); else passed++;
        end
    endtask

    task automatic test_mul();
        run_table("mul", '{3'd0, 3'd1, 3'd3, 3'd2},
                  '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF}, 2);
    endtask

    task automatic test_div();
        run_table("div", '{3'd4, 3'd6, 3'd5, 3'd7},
                  '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100},
                  '{32'd2, 32'd2, 32'd7, 32'd7},
                  '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2}, 33);
    endtask

    task automatic test_special();
        run_table("special", '{3'd5, 3'd7, 3'd4, 3'd6},
                  '{32'd100, 32'd100, 32'h80000000, 32'h80000000},
                  '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'd0}, 1);
    endtask

    task automatic test_hold_operands();
        logic [31:0] res;
        int lat, bc;
        logic db, av;
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1, res, lat, bc, db, av);
        total++; if (res !== 32'hFFFFFFFD) $display("FAIL hold_result: got %h want FFFFFFFD", res); else passed++;
        total++; if (av !== 1'b0) $display("FAIL hold_single_pulse: second valid=%b want 0", av); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'hFFFFFFFD)
                $display("FAIL hold_idle[%0d]: busy=%b valid=%b result=%h want 0 0 FFFFFFFD", i, busy, result_valid, result);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int l1, l2, b1, b2;
        logic d1, d2, a1, a2;
        do_op(3'd5, 32'd10, 32'd3, 1'b0, r1, l1, b1, d1, a1);
        do_op(3'd0, 32'd6, 32'd7, 1'b0, r2, l2, b2, d2, a2);
        total++; if (r1 !== 32'd3) $display("FAIL b2b_first: got %h want 00000003", r1); else passed++;
        total++; if (a1 !== 1'b0) $display("FAIL b2b_dup_valid: got %b want 0", a1); else passed++;
        total++; if (r2 !== 32'd42) $display("FAIL b2b_second: got %h want 0000002a", r2); else passed++;
        total++; if (l2 != 2 || b2 != 2) $display("FAIL b2b_second_timing: lat=%0d busy=%0d want 2 2", l2, b2); else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat, bc;
        logic db, av;
        start = 1'b1; funct3E = 3'd5; SrcAE = 32'h12345678; SrcBE = 32'd7;
        repeat (10) @(posedge clk);
        #3;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0)
            $display("FAIL async_reset: busy=%b valid=%b result=%h want 0 0 00000000", busy, result_valid, result);
        else passed++;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (result_valid !== 1'b0) $display("FAIL async_reset_no_result: got %b want 0", result_valid); else passed++;
        do_op(3'd0, 32'd2, 32'd3, 1'b0, res, lat, bc, db, av);
        total++; if (res !== 32'd6 || lat != 2) $display("FAIL post_reset_mul: result=%h lat=%0d want 00000006 2", res, lat); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp_r;
        logic [2:0]  op;
        int lat, bc, k;
        logic db, av;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            k  = $urandom_range(0, 7);
            if (k == 0) b = 32'd0;
            else if (k == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (k == 2) b = 32'($urandom_range(1, 15));
            exp_r = ref_res(op, a, b);
            do_op(op, a, b, 1'b0, res, lat, bc, db, av);
            total++;
            if (res !== exp_r) $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp_r);
            else passed++;
            total++;
            if (lat != ref_lat(op, a, b)) $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, ref_lat(op, a, b));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_hold_operands();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
